// File: rtl/mmio_pkg.sv
// Shared constants for the cpu-side MMIO bridge: I/O page base and register offsets.
package mmio_pkg;

    localparam logic [15:0] IO_BASE_DEFAULT = 16'hFF00;

    localparam logic [7:0] MMIO_TIMER   = 8'h00;
    localparam logic [7:0] MMIO_BUTTONS = 8'h01;
    localparam logic [7:0] MMIO_EVENTS  = 8'h02;
    localparam logic [7:0] MMIO_LEDS    = 8'h03;

endpackage

// File: rtl/mmio_bridge_button_conditioner.sv
// Button input conditioning: two-flop synchroniser, optional debounce, and
// rising-edge detection on the accepted level.
// Optional feature: define MMIO_DEBOUNCE_EN to require DEBOUNCE_CYCLES stable
// cycles before a synchronised level is accepted.
module button_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;

    // Synchroniser chain and previous-level capture for edge detection
    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        prev_d  = level;
    end

    // Synchroniser and previous-level registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

`ifdef MMIO_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] accepted_q, accepted_d;

    // Count consecutive cycles the synchronised level disagrees with the accepted one
    always_comb begin
        accepted_d = accepted_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != accepted_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    accepted_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce counters and accepted level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            accepted_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            accepted_q <= accepted_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign level = accepted_q;
`else
    // Without debounce the synchroniser output is accepted directly.
    logic [31:0] unused_debounce_cycles;
    assign unused_debounce_cycles = 32'(DEBOUNCE_CYCLES);
    assign level = sync2_q;
`endif

    assign rise = level & ~prev_q;

endmodule

// File: rtl/mmio_bridge.sv
// Address decoder between the cpu memory port and block RAM, with a small
// I/O page (ms timer, buttons, edge events, LEDs) read back with the same
// one-cycle latency as the RAM.
// Optional feature: MMIO_DEBOUNCE_EN enables button debouncing.
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter logic [15:0] IO_BASE         = IO_BASE_DEFAULT,
    parameter int          TICK_DIVISOR    = 50000,
    parameter int          BUTTON_COUNT    = 4,
    parameter int          DEBOUNCE_CYCLES = 250000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [15:0]             cpu_memory_address,
    input  logic [15:0]             cpu_memory_write_data,
    input  logic                    cpu_memory_write_enable,
    output logic [15:0]             cpu_memory_read_data,
    output logic [15:0]             ram_address,
    output logic [15:0]             ram_write_data,
    output logic                    ram_write_enable,
    input  logic [15:0]             ram_read_data,
    input  logic [BUTTON_COUNT-1:0] buttons_in,
    output logic [15:0]             leds_out
);

    localparam int PW = $clog2(TICK_DIVISOR);
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(TICK_DIVISOR - 1);

    logic       is_io;
    logic [7:0] offset;
    logic       wr_io;

    logic [PW-1:0]           prescaler_q, prescaler_d;
    logic [15:0]             timer_q, timer_d;
    logic [BUTTON_COUNT-1:0] events_q, events_d;
    logic [15:0]             leds_q, leds_d;
    logic                    sel_io_q, sel_io_d;
    logic [7:0]              off_q, off_d;
    logic [15:0]             io_rdata_q, io_rdata_d;

    logic [BUTTON_COUNT-1:0] btn_level;
    logic [BUTTON_COUNT-1:0] btn_rise;
    logic                    tick;

    assign is_io  = (cpu_memory_address >= IO_BASE);
    assign offset = cpu_memory_address[7:0];
    assign wr_io  = cpu_memory_write_enable & is_io;

    assign ram_address      = cpu_memory_address;
    assign ram_write_data   = cpu_memory_write_data;
    assign ram_write_enable = cpu_memory_write_enable & ~is_io;

    assign tick     = (prescaler_q == PRESCALE_LAST);
    assign leds_out = leds_q;

    button_conditioner #(
        .WIDTH           (BUTTON_COUNT),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_buttons (
        .clock  (clock),
        .reset  (reset),
        .raw_in (buttons_in),
        .level  (btn_level),
        .rise   (btn_rise)
    );

    // Millisecond timer: a write clears everything and beats a coincident tick
    always_comb begin
        prescaler_d = prescaler_q + 1'b1;
        timer_d     = timer_q;
        if (wr_io && offset == MMIO_TIMER) begin
            prescaler_d = '0;
            timer_d     = '0;
        end else if (tick) begin
            prescaler_d = '0;
            timer_d     = timer_q + 16'd1;
        end
    end

    // Event latching (rising edge beats W1C) and LED register writes
    always_comb begin
        events_d = events_q;
        leds_d   = leds_q;
        if (wr_io && offset == MMIO_EVENTS) begin
            events_d = events_q & ~cpu_memory_write_data[BUTTON_COUNT-1:0];
        end
        events_d = events_d | btn_rise;
        if (wr_io && offset == MMIO_LEDS) begin
            leds_d = cpu_memory_write_data;
        end
    end

    // Capture the I/O read value and routing decision for next-cycle return
    always_comb begin
        sel_io_d   = is_io;
        off_d      = offset;
        io_rdata_d = '0;
        case (offset)
            MMIO_TIMER:   io_rdata_d = timer_q;
            MMIO_BUTTONS: io_rdata_d = 16'(btn_level);
            MMIO_EVENTS:  io_rdata_d = 16'(events_q);
            MMIO_LEDS:    io_rdata_d = leds_q;
            default:      io_rdata_d = '0;
        endcase
    end

    // I/O page registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler_q <= '0;
            timer_q     <= '0;
            events_q    <= '0;
            leds_q      <= '0;
            sel_io_q    <= 1'b0;
            off_q       <= '0;
            io_rdata_q  <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            timer_q     <= timer_d;
            events_q    <= events_d;
            leds_q      <= leds_d;
            sel_io_q    <= sel_io_d;
            off_q       <= off_d;
            io_rdata_q  <= io_rdata_d;
        end
    end

    // Return RAM data unless the previous cycle addressed the I/O page;
    // unmapped offsets always read as zero
    always_comb begin
        cpu_memory_read_data = ram_read_data;
        if (sel_io_q) begin
            cpu_memory_read_data = (off_q <= MMIO_LEDS) ? io_rdata_q : 16'h0000;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed vector table, hand sequences
// for timer wrap / event collisions / debounce / async reset, and a random
// phase checked against a behavioural model of the register map.
module tb_mmio_bridge;

    localparam int TICK = 4;
    localparam int NB   = 4;
    localparam int DB   = 8;
`ifdef MMIO_DEBOUNCE_EN
    localparam int LAT = 12;
`else
    localparam int LAT = 4;
`endif

    logic          clock;
    logic          reset;
    logic [15:0]   cpu_memory_address;
    logic [15:0]   cpu_memory_write_data;
    logic          cpu_memory_write_enable;
    logic [15:0]   cpu_memory_read_data;
    logic [15:0]   ram_address;
    logic [15:0]   ram_write_data;
    logic          ram_write_enable;
    logic [15:0]   ram_read_data;
    logic [NB-1:0] buttons_in;
    logic [15:0]   leds_out;

    int tests = 0;
    int fails = 0;

    mmio_bridge #(
        .IO_BASE         (16'hFF00),
        .TICK_DIVISOR    (TICK),
        .BUTTON_COUNT    (NB),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .cpu_memory_address      (cpu_memory_address),
        .cpu_memory_write_data   (cpu_memory_write_data),
        .cpu_memory_write_enable (cpu_memory_write_enable),
        .cpu_memory_read_data    (cpu_memory_read_data),
        .ram_address             (ram_address),
        .ram_write_data          (ram_write_data),
        .ram_write_enable        (ram_write_enable),
        .ram_read_data           (ram_read_data),
        .buttons_in              (buttons_in),
        .leds_out                (leds_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Block RAM stand-in: registered read, read-before-write
    logic [15:0] ram_mem [65536];
    initial begin
        for (int i = 0; i < 65536; i++) ram_mem[i] = 16'h0000;
        ram_mem[16'hFF02] = 16'h5A5A;
        ram_read_data = 16'h0000;
        forever begin
            @(posedge clock);
            ram_read_data = ram_mem[ram_address];
            if (ram_write_enable) ram_mem[ram_address] = ram_write_data;
        end
    end

    // Behavioural reference: expected read data for the access made at each edge
    logic [15:0]   gold [65536];
    int            m_cyc = 0;
    logic [NB-1:0] m_ev = '0, m_prev = '0, h1 = '0, h2 = '0, h3 = '0;
    logic [15:0]   m_leds = '0, m_rd = '0;
`ifdef MMIO_DEBOUNCE_EN
    logic [NB-1:0] m_acc = '0;
    int            m_run [NB];
`endif
    initial begin : model
        logic [NB-1:0] lvl, rise, w1c;
        logic          io, tclr;
        for (int i = 0; i < 65536; i++) gold[i] = 16'h0000;
        gold[16'hFF02] = 16'h5A5A;
`ifdef MMIO_DEBOUNCE_EN
        for (int i = 0; i < NB; i++) m_run[i] = 0;
`endif
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                m_cyc = 0; m_ev = '0; m_prev = '0; m_leds = '0;
                h1 = '0; h2 = '0; h3 = '0;
`ifdef MMIO_DEBOUNCE_EN
                m_acc = '0;
                for (int i = 0; i < NB; i++) m_run[i] = 0;
`endif
            end else begin
                io = (cpu_memory_address >= 16'hFF00);
`ifdef MMIO_DEBOUNCE_EN
                lvl = m_acc;
                for (int i = 0; i < NB; i++) begin
                    if (h2[i] != m_acc[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DB) begin
                            m_acc[i] = h2[i];
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
`else
                lvl = h2;
`endif
                rise   = lvl & ~m_prev;
                m_prev = lvl;
                if (io) begin
                    case (cpu_memory_address[7:0])
                        8'h00:   m_rd = 16'(m_cyc / TICK);
                        8'h01:   m_rd = 16'(lvl);
                        8'h02:   m_rd = 16'(m_ev);
                        8'h03:   m_rd = m_leds;
                        default: m_rd = 16'h0000;
                    endcase
                end else begin
                    m_rd = gold[cpu_memory_address];
                end
                w1c  = '0;
                tclr = 1'b0;
                if (cpu_memory_write_enable && io) begin
                    case (cpu_memory_address[7:0])
                        8'h00:   tclr = 1'b1;
                        8'h02:   w1c = cpu_memory_write_data[NB-1:0];
                        8'h03:   m_leds = cpu_memory_write_data;
                        default: ;
                    endcase
                end
                if (cpu_memory_write_enable && !io) gold[cpu_memory_address] = cpu_memory_write_data;
                if (tclr) m_cyc = 0;
                else      m_cyc++;
                m_ev = (m_ev & ~w1c) | rise;
                h3 = h2; h2 = h1; h1 = buttons_in;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic w);
        cpu_memory_address      = a;
        cpu_memory_write_data   = d;
        cpu_memory_write_enable = w;
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic        exp_ram_we;
        logic        chk;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl [11];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin : main
        tbl[0]  = '{16'h0010, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[1]  = '{16'h0010, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234};
        tbl[2]  = '{16'hFF03, 16'hA5A5, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[3]  = '{16'hFF03, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5};
        tbl[4]  = '{16'hFF7F, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[5]  = '{16'hFF00, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[6]  = '{16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000};
        tbl[7]  = '{16'hFFFF, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000};
        tbl[8]  = '{16'hFEFF, 16'h5555, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[9]  = '{16'hFEFF, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h5555};
        tbl[10] = '{16'hFF03, 16'h0000, 1'b0, 1'b0, 1'b1, 16'hA5A5};

        reset = 1'b1;
        buttons_in = '0;
        drive(16'h0000, 16'h0000, 1'b0);
        repeat (2) @(negedge clock);
        check("reset_rd", cpu_memory_read_data, 16'h0000);
        check("reset_leds", leds_out, 16'h0000);
        reset = 1'b0;

        // Timer: 40 cycles at 4 cycles per tick
        repeat (40) @(negedge clock);
        drive(16'hFF00, 16'h0000, 1'b0);
        @(negedge clock);
        check("timer_40", cpu_memory_read_data, 16'd10);

        // Directed vector table
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].addr, tbl[i].wdata, tbl[i].we);
            #1;
            check($sformatf("vec%0d_ram_we", i), 16'(ram_write_enable), 16'(tbl[i].exp_ram_we));
            @(negedge clock);
            if (tbl[i].chk) check($sformatf("vec%0d_rd", i), cpu_memory_read_data, tbl[i].exp_rd);
        end
        check("leds_out", leds_out, 16'hA5A5);

        // Timer wrap FFFF -> 0000
        drive(16'hFF00, 16'h0000, 1'b1);
        @(negedge clock);
        drive(16'h0000, 16'h0000, 1'b0);
        force dut.timer_q = 16'hFFFF;
        @(negedge clock);
        release dut.timer_q;
        m_cyc = 65535 * TICK + 1;
        drive(16'hFF00, 16'h0000, 1'b0);
        @(negedge clock);
        check("wrap_pre", cpu_memory_read_data, 16'hFFFF);
        repeat (3) @(negedge clock);
        check("wrap_post", cpu_memory_read_data, 16'h0000);

        // Rising edge on button 2 and its latency into EVENTS
        drive(16'hFF02, 16'h0000, 1'b0);
        buttons_in = 4'b0100;
        repeat (LAT - 1) @(negedge clock);
        check("ev_early", cpu_memory_read_data, 16'h0000);
        @(negedge clock);
        check("ev_rise", cpu_memory_read_data, 16'h0004);
        drive(16'hFF01, 16'h0000, 1'b0);
        @(negedge clock);
        check("buttons_lvl", cpu_memory_read_data, 16'h0004);
        drive(16'hFF02, 16'h0000, 1'b1);
        @(negedge clock);
        drive(16'hFF02, 16'h0000, 1'b0);
        @(negedge clock);
        check("ev_w0", cpu_memory_read_data, 16'h0004);
        drive(16'hFF02, 16'h0004, 1'b1);
        @(negedge clock);
        drive(16'hFF02, 16'h0000, 1'b0);
        @(negedge clock);
        check("ev_w1c", cpu_memory_read_data, 16'h0000);

        // Falling edge sets nothing; then an edge coincident with W1C stays set
        buttons_in = 4'b0000;
        repeat (20) @(negedge clock);
        check("ev_fall", cpu_memory_read_data, 16'h0000);
        buttons_in = 4'b0100;
        repeat (LAT - 2) @(negedge clock);
        drive(16'hFF02, 16'h0004, 1'b1);
        @(negedge clock);
        drive(16'hFF02, 16'h0000, 1'b0);
        @(negedge clock);
        check("ev_collide", cpu_memory_read_data, 16'h0004);
        drive(16'hFF02, 16'hFFFF, 1'b1);
        @(negedge clock);
        drive(16'hFF02, 16'h0000, 1'b0);

`ifdef MMIO_DEBOUNCE_EN
        // Glitch shorter than the debounce window is filtered out
        buttons_in = 4'b0101;
        repeat (5) @(negedge clock);
        buttons_in = 4'b0100;
        repeat (20) @(negedge clock);
        check("db_glitch", cpu_memory_read_data, 16'h0000);
        buttons_in = 4'b0101;
        repeat (12) @(negedge clock);
        buttons_in = 4'b0100;
        repeat (20) @(negedge clock);
        check("db_pulse", cpu_memory_read_data, 16'h0001);
        drive(16'hFF02, 16'hFFFF, 1'b1);
        @(negedge clock);
        drive(16'hFF02, 16'h0000, 1'b0);
`endif

        // Randomised traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            int unsigned r;
            int          b;
            logic [15:0] a;
            @(negedge clock);
            check("rand_rd", cpu_memory_read_data, m_rd);
            check("rand_leds", leds_out, m_leds);
            r = $urandom_range(0, 9);
            if (r < 5)       a = 16'($urandom_range(0, 63));
            else if (r == 5) a = ($urandom_range(0, 1) == 0) ? 16'hFEFF : 16'hFF00;
            else if (r < 9)  a = 16'hFF00 + 16'($urandom_range(0, 4));
            else             a = {8'hFF, 8'($urandom)};
            drive(a, 16'($urandom), ($urandom_range(0, 2) == 0));
            if ($urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, NB - 1);
                buttons_in[b] = ~buttons_in[b];
            end
            #1;
            check("rand_ram_we", 16'(ram_write_enable),
                  16'(cpu_memory_write_enable && (cpu_memory_address < 16'hFF00)));
        end

        // Async reset with LEDS=FFFF and EVENTS=000F
        @(negedge clock);
        drive(16'hFF03, 16'hFFFF, 1'b1);
        buttons_in = 4'b0000;
        @(negedge clock);
        drive(16'h0000, 16'h0000, 1'b0);
        repeat (20) @(negedge clock);
        drive(16'hFF02, 16'hFFFF, 1'b1);
        @(negedge clock);
        drive(16'hFF02, 16'h0000, 1'b0);
        buttons_in = 4'b1111;
        repeat (20) @(negedge clock);
        check("pre_rst_ev", cpu_memory_read_data, 16'h000F);
        check("pre_rst_leds", leds_out, 16'hFFFF);
        #2;
        reset = 1'b1;
        #1;
        check("rst_leds", leds_out, 16'h0000);
        check("rst_rd_mux", cpu_memory_read_data, 16'h5A5A);
        buttons_in = 4'b0000;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_ev", cpu_memory_read_data, 16'h0000);
        drive(16'hFF03, 16'h0000, 1'b0);
        @(negedge clock);
        check("post_rst_leds_rd", cpu_memory_read_data, 16'h0000);
        check("post_rst_leds", leds_out, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_bridge.md
Name: mmio_bridge

Overview:
- Sits between the cpu memory port and the block RAM: decodes each cpu address to RAM or to a small memory-mapped I/O page and returns read data with the same one-cycle registered latency as the RAM.
- I/O page contains:
  - a millisecond timer;
  - synchronised button inputs with edge-event latching;
  - an LED output register.
- Gives the cpu program input, timing and output without changing the controller.

Parameters:
- IO_BASE, 16'hFF00, base of 256-word I/O page; addresses at or above it never reach RAM.
- TICK_DIVISOR, 50000, clock cycles per timer tick (1 ms at 50 MHz); must be ≥2.
- BUTTON_COUNT, 4, number of button inputs (1..16).
- DEBOUNCE_CYCLES, 250000, stable cycles required before a button level is accepted (debounce only).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_memory_address  in  16  address from cpu
- cpu_memory_write_data  in  16  store data from cpu
- cpu_memory_write_enable  in  1  store strobe from cpu
- cpu_memory_read_data  out  16  load data to cpu, valid one cycle after address
- ram_address  out  16  address to block RAM
- ram_write_data  out  16  store data to block RAM
- ram_write_enable  out  1  RAM write strobe, gated by decode
- ram_read_data  in  16  RAM read data, registered, one-cycle latency
- buttons_in  in  BUTTON_COUNT  raw asynchronous button levels
- leds_out  out  16  LED register contents

Behaviour:
- Decode: is_io = (cpu_memory_address >= IO_BASE). The offset is the low 8 bits.
- RAM path:
  - ram_address and ram_write_data are combinational pass-through.
  - ram_write_enable = cpu_memory_write_enable & ~is_io.
- Read mux:
  - is_io and the offset are registered each cycle into sel_io_q and off_q.
  - The I/O read value is captured into io_rdata_q in the same cycle.
  - cpu_memory_read_data = sel_io_q ? io_rdata_q : ram_read_data.
  - Latency is exactly one cycle for both paths.
- Register map (offset, access):
  - 0x00 TIMER, R: ms count. Any write clears both the count and the prescaler to 0.
  - 0x01 BUTTONS, R: synchronised (debounced if enabled) levels, zero-extended.
  - 0x02 EVENTS, R/W1C: bit i set on a rising edge of accepted level i. Writing 1 clears the bit; writing 0 leaves it unchanged.
  - 0x03 LEDS, R/W: full 16-bit register driving leds_out.
  - other offsets: read 0, writes ignored.
- Timer:
  - The prescaler counts 0..TICK_DIVISOR-1.
  - On the terminal count the prescaler returns to 0 and TIMER increments.
  - TIMER is 16-bit and wraps FFFF→0000.
  - A write to TIMER in the same cycle as a tick wins: the result is 0.
- Buttons:
  - Two-flop synchroniser per bit, then a previous-level register for edge detection.
  - Edge-to-EVENTS latency is 3 cycles from the input change.
- W1C collision: a rising edge in the same cycle as a W1C of that bit leaves the bit set (set wins).
- A read of EVENTS returns the value before any same-cycle update. Reads have no side effects.
- Reset (async, active-high), all cleared to 0:
  - TIMER, prescaler, LEDS, EVENTS;
  - synchroniser and previous-level flops;
  - sel_io_q, off_q, io_rdata_q.
  - After reset, cpu_memory_read_data = ram_read_data until the first I/O access is registered.
  - Reset mid-access aborts it; no partial register update.
- A write is single-cycle: each cycle with cpu_memory_write_enable=1 and a matching address performs the write.
- Holding a write for N cycles is idempotent except for TIMER, which stays cleared.

Optional Feature:
- Macro: MMIO_DEBOUNCE_EN.
- Defined:
  - Each synchronised bit has a counter up to DEBOUNCE_CYCLES.
  - The accepted level changes only after the raw synchronised level has differed from it for DEBOUNCE_CYCLES consecutive cycles.
  - A counter restarts when the raw level returns to the accepted level.
  - Edges and BUTTONS use the accepted level.
- Undefined: the accepted level is the synchroniser output directly, and DEBOUNCE_CYCLES is unused.

Decomposition:
- Shared package mmio_pkg holds:
  - offset constants MMIO_TIMER=8'h00, MMIO_BUTTONS=8'h01, MMIO_EVENTS=8'h02, MMIO_LEDS=8'h03;
  - the default IO_BASE.
- One natural sub-module, button_conditioner, instantiated once with width BUTTON_COUNT. It contains:
  - the synchroniser;
  - the optional debounce;
  - the edge-detect, with outputs level and rise pulse.

Test Plan:
- RAM pass-through: write 0x1234 to 0x0010, then read 0x0010 → ram_write_enable high for one cycle; read returns 0x1234 one cycle later. A write to 0xFF03 never asserts ram_write_enable.
- LEDS: write 0xA5A5 to 0xFF03 → leds_out=0xA5A5 next cycle; read 0xFF03 returns 0xA5A5. Read 0xFF7F returns 0x0000.
- Timer (TICK_DIVISOR=4): after reset run 40 cycles → TIMER reads 10.
  - Writing any value to 0xFF00 gives a read of 0.
  - Preload to 0xFFFF by forcing, then one tick → 0x0000.
- Events: raise buttons_in[2] → EVENTS=0x0004 after 3 cycles, BUTTONS=0x0004.
  - Write 0x0004 to 0xFF02 → 0x0000.
  - An edge coinciding with the W1C leaves 0x0004.
- Debounce (MMIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=8):
  - 5-cycle glitch on buttons_in[0] → no event;
  - 12-cycle pulse → EVENTS bit 0 set.
- Async reset asserted mid-stream with LEDS=0xFFFF and EVENTS=0x000F → all read 0 and leds_out=0 immediately, without waiting for a clock edge.
